dmem_arbiter: RTL and testbench

Single-port data-memory arbiter sharing the processor's dmem port between the processor MEM stage (core side) and a host/loader port (UART boot loader or debug). Core has priority. A starvation counter guarantees the host a slot within a bounded number of cycles. While the host owns the memory, the arbiter raises `core_stall` to the stage FSM so the pipeline freezes. Sits between `dsd_processor` dmem signals and the memory macro.

---
 rtl/dsd_pkg.sv | 20 ++
 rtl/arb_streak_cnt.sv | 34 +++
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsd_pkg.sv
// rtl/dsd_pkg.sv - shared types and default widths for the dsd processor memory path
package dsd_pkg;

    // Arbiter state: records which side owned the memory in the previous cycle.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CORE        = 2'd1,
        HOST        = 2'd2,
        HOST_LOCKED = 2'd3
    } arb_state_t;

    localparam int DSD_AW = 16;
    localparam int DSD_DW = 32;

    // 16-bit counter step that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/arb_streak_cnt.sv
// rtl/arb_streak_cnt.sv - saturating streak counter with increment, clear and limit
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   inc        : count up by one (ignored once count reaches limit)
//   clr        : return to zero; wins over inc
//   limit      : saturation value
//   count      : current count
//   at_limit   : count == limit
module arb_streak_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         at_limit
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count < limit)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/host arbiter for the single-port data memory
//
// The core (MEM stage) normally wins; a streak counter hands the host a slot
// after STARVE_LIMIT consecutive core grants while the host waits, and a
// locked host burst holds the memory until host_lock drops or host_req drops.
// Optional macro DMEM_ARB_STATS_EN adds saturating host-beat and stall counters.
//
// Ports:
//   clk, reset                        : clock, asynchronous active-high reset
//   core_req/addr/wdata/we, core_stall: MEM-stage request and pipeline hold
//   host_req/lock/addr/wdata/we       : host/loader request, lock keeps a burst
//   host_gnt                          : host beat accepted this cycle
//   host_rvalid, host_rdata           : host read data, one cycle after grant
//   mem_addr/wdata/we, mem_rdata      : memory macro port
//   stat_host_beats, stat_stall_cycles: statistics (DMEM_ARB_STATS_EN only)
module dmem_arbiter
    import dsd_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = DSD_AW,
    parameter int DW           = DSD_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    input  logic          core_we,
    output logic          core_stall,
    input  logic          host_req,
    input  logic          host_lock,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_we,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]   stat_host_beats,
    output logic [15:0]   stat_stall_cycles,
`endif
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t    state;
    arb_state_t    state_next;
    logic          host_win;
    logic          core_win;
    logic [3:0]    streak;
    logic          streak_full;
    logic          rvalid_q;
    logic [AW-1:0] addr_q;

    // Host never waits more than STARVE_LIMIT core grants in a row.
    arb_streak_cnt #(.W(4)) u_streak (
        .clk      (clk),
        .reset    (reset),
        .inc      (core_win & host_req),
        .clr      (host_win | ~host_req),
        .limit    (LIMIT),
        .count    (streak),
        .at_limit (streak_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        host_win   = 1'b0;
        core_win   = 1'b0;
        state_next = IDLE;
        if (host_req && ((state == HOST_LOCKED) || !core_req || streak_full)) begin
            host_win = 1'b1;
        end else if (core_req) begin
            core_win = 1'b1;
        end
        if (host_win) begin
            state_next = host_lock ? HOST_LOCKED : HOST;
        end else if (core_win) begin
            state_next = CORE;
        end
    end

    // Address register lets mem_addr hold steady across idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (host_win) begin
                addr_q <= host_addr;
            end else if (core_win) begin
                addr_q <= core_addr;
            end
            rvalid_q <= host_win & ~host_we;
        end
    end

    // Every output is forced low while reset is held, including the
    // combinational grant/stall paths that would otherwise follow the inputs.
    always_comb begin
        mem_addr    = addr_q;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        host_gnt    = 1'b0;
        core_stall  = 1'b0;
        host_rvalid = 1'b0;
        host_rdata  = '0;
        if (!reset) begin
            if (host_win) begin
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
                mem_we    = host_we;
            end else if (core_win) begin
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
                mem_we    = core_we;
            end
            host_gnt    = host_win;
            core_stall  = core_req & ~core_win;
            host_rvalid = rvalid_q;
            if (rvalid_q) begin
                host_rdata = mem_rdata;
            end
        end else begin
            mem_addr = '0;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_host_beats   <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (host_gnt) begin
                stat_host_beats <= sat_inc16(stat_host_beats);
            end
            if (core_stall) begin
                stat_stall_cycles <= sat_inc16(stat_stall_cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req;
    logic [15:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_we;
    logic        core_stall;
    logic        host_req;
    logic        host_lock;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_we;
    logic        host_gnt;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_host_beats;
    logic [15:0] stat_stall_cycles;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(4), .AW(16), .DW(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .core_req    (core_req),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_we     (core_we),
        .core_stall  (core_stall),
        .host_req    (host_req),
        .host_lock   (host_lock),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_we     (host_we),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
`ifdef DMEM_ARB_STATS_EN
        .stat_host_beats   (stat_host_beats),
        .stat_stall_cycles (stat_stall_cycles),
`endif
        .mem_rdata   (mem_rdata)
    );

    // Synchronous memory model: read data one cycle after the address.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        core_req = 0; core_addr = 0; core_wdata = 0; core_we = 0;
        host_req = 0; host_lock = 0; host_addr = 0; host_wdata = 0; host_we = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        // Outputs must be low in reset even with an active core request.
        core_req = 1; core_we = 1; core_addr = 16'h0010; core_wdata = 32'h1111_2222;
        host_req = 1;
        #3;
        check("rst_core_stall", {31'd0, core_stall}, 32'd0);
        check("rst_mem_we",     {31'd0, mem_we},     32'd0);
        check("rst_mem_addr",   {16'd0, mem_addr},   32'd0);
        check("rst_host_gnt",   {31'd0, host_gnt},   32'd0);
        check("rst_mem_wdata",  mem_wdata,           32'd0);
        tick(); tick();
        reset = 1'b0;
        clear_inputs();
        #1;

        // Core only: write 0x1234_5678 to 0x0010 for three cycles.
        core_req = 1; core_we = 1; core_addr = 16'h0010; core_wdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("core_mem_we",    {31'd0, mem_we},     32'd1);
            check("core_mem_addr",  {16'd0, mem_addr},   32'h0010);
            check("core_mem_wdata", mem_wdata,           32'h1234_5678);
            check("core_stall_lo",  {31'd0, core_stall}, 32'd0);
            tick();
        end
        core_addr = 16'h0020; core_wdata = 32'hDEAD_BEEF;
        tick();

        // No owner: address holds, write data and enable drop.
        clear_inputs();
        #1;
        check("idle_addr_hold", {16'd0, mem_addr}, 32'h0020);
        check("idle_wdata",     mem_wdata,         32'd0);
        check("idle_we",        {31'd0, mem_we},   32'd0);
        tick();

        // Contention: core for 4 cycles, host on the 5th, then core again.
        core_req = 1; core_addr = 16'h0030;
        host_req = 1; host_we = 1; host_addr = 16'h0040; host_wdata = 32'hA5A5_A5A5;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("cont_gnt_%0d", i),   {31'd0, host_gnt},   {31'd0, i == 4});
            check($sformatf("cont_stall_%0d", i), {31'd0, core_stall}, {31'd0, i == 4});
            check($sformatf("cont_addr_%0d", i),  {16'd0, mem_addr},   (i == 4) ? 32'h0040 : 32'h0030);
            tick();
        end
        clear_inputs();
        tick();

        // Host reads: grant at N, data at N+1, nothing afterwards.
        host_req = 1; host_addr = 16'h0020;
        #1;
        check("hrd_gnt",       {31'd0, host_gnt},    32'd1);
        check("hrd_rvalid_n",  {31'd0, host_rvalid}, 32'd0);
        check("hrd_addr",      {16'd0, mem_addr},    32'h0020);
        tick();
        host_addr = 16'h0010;
        #1;
        check("hrd_rvalid_n1", {31'd0, host_rvalid}, 32'd1);
        check("hrd_rdata_n1",  host_rdata,           32'hDEAD_BEEF);
        tick();
        host_req = 0;
        #1;
        check("hrd2_rvalid",   {31'd0, host_rvalid}, 32'd1);
        check("hrd2_rdata",    host_rdata,           32'h1234_5678);
        tick();
        #1;
        check("hrd_rvalid_off", {31'd0, host_rvalid}, 32'd0);
        check("hrd_rdata_off",  host_rdata,           32'd0);
        tick();

        // Locked burst entered through starvation: host owns cycles 4..6.
        core_req = 1; core_addr = 16'h0030;
        host_req = 1; host_lock = 1; host_we = 1; host_addr = 16'h0050;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) host_lock = 0;
            #1;
            check($sformatf("lock_stall_%0d", i), {31'd0, core_stall}, {31'd0, (i >= 4) && (i <= 6)});
            check($sformatf("lock_gnt_%0d", i),   {31'd0, host_gnt},   {31'd0, (i >= 4) && (i <= 6)});
            tick();
        end
        clear_inputs();
        tick();

        // host_req dropping in HOST_LOCKED hands the memory straight to the core.
        host_req = 1; host_lock = 1; host_addr = 16'h0060; host_we = 1;
        #1;
        check("drop_gnt", {31'd0, host_gnt}, 32'd1);
        tick();
        host_req = 0; core_req = 1; core_addr = 16'h0070;
        #1;
        check("drop_core_stall", {31'd0, core_stall}, 32'd0);
        check("drop_addr",       {16'd0, mem_addr},   32'h0070);
        tick();
        clear_inputs();
        tick();

        // Reset in the cycle after a host read grant drops the read response.
        host_req = 1; host_addr = 16'h0020;
        #1;
        check("rmr_gnt", {31'd0, host_gnt}, 32'd1);
        tick();
        reset = 1; host_req = 0; core_req = 1; core_addr = 16'h0080;
        #1;
        check("rmr_rvalid", {31'd0, host_rvalid}, 32'd0);
        check("rmr_rdata",  host_rdata,           32'd0);
        check("rmr_addr",   {16'd0, mem_addr},    32'd0);
        tick();
        reset = 0;
        #1;
        check("rmr_core_stall", {31'd0, core_stall}, 32'd0);
        check("rmr_core_addr",  {16'd0, mem_addr},   32'h0080);
        check("rmr_rvalid_after", {31'd0, host_rvalid}, 32'd0);
        tick();
        clear_inputs();

`ifdef DMEM_ARB_STATS_EN
        reset = 1;
        tick();
        reset = 0;
        // 5 host-only beats, no stalls.
        host_req = 1; host_we = 1; host_addr = 16'h0090;
        for (int i = 0; i < 5; i++) tick();
        host_req = 0;
        #1;
        check("stat_beats_5",  {16'd0, stat_host_beats},   32'd5);
        check("stat_stalls_0", {16'd0, stat_stall_cycles}, 32'd0);
        // Locked entry with idle core, then 7 stalled locked beats.
        host_req = 1; host_lock = 1;
        tick();
        core_req = 1;
        for (int i = 0; i < 7; i++) tick();
        clear_inputs();
        #1;
        check("stat_beats_13", {16'd0, stat_host_beats},   32'd13);
        check("stat_stalls_7", {16'd0, stat_stall_cycles}, 32'd7);
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
